icmp_msg_parser: RTL and testbench

ICMP_MSG_PARSER -- requirements
Module: icmp_msg_parser

---
 rtl/icmp_msg_parser.sv | 184 ++++++++++++++++++
 tb/tb_icmp_msg_parser.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icmp_msg_parser.sv
// icmp_msg_parser: splits a word stream into ICMP header fields and a fixed
// number of payload words, and holds the result until downstream takes it.
//
// Optional feature: define ICMP_CSUM_CHECK_EN to build the one's-complement
// checksum accumulator that drives csum_ok. Without it, csum_ok is tied to 1.
//
// Handshake: a word moves on the input side only when in_valid && in_ready,
// and the parsed result moves on the output side only when out_valid &&
// out_ready. Valid never waits on ready. Once out_valid is high, every output
// stays unchanged until the output handshake completes.
module icmp_msg_parser #(
  parameter int PAYLOAD_WORDS = 3,
  parameter int CNT_W         = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [31:0]                in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 icmp_type,
  output logic [7:0]                 icmp_code,
  output logic [15:0]                checksum,
  output logic [31:0]                rest_hdr,
  output logic [PAYLOAD_WORDS*32-1:0] payload,
  output logic [CNT_W-1:0]           payload_cnt,
  output logic                       truncated,
  output logic                       len_err,
  output logic                       csum_ok,
  output logic [1:0]                 state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [31:0]                word0_q, word0_d;
  logic [31:0]                rest_hdr_q, rest_hdr_d;
  logic [PAYLOAD_WORDS*32-1:0] payload_q, payload_d;
  logic [CNT_W-1:0]           payload_cnt_q, payload_cnt_d;
  logic                       truncated_q, truncated_d;
  logic                       len_err_q, len_err_d;
  logic                       xfer;

  assign xfer = in_valid && in_ready;

  // State register; reset drops any partial message back to IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: advance on accepted words, leave DONE on the output handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (xfer) state_d = in_last ? S_DONE : S_HDR;
      S_HDR:  if (xfer) state_d = in_last ? S_DONE : S_PAY;
      S_PAY:  if (xfer && in_last) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: accept words everywhere except while holding a result.
  always_comb begin
    in_ready  = (state_q != S_DONE);
    out_valid = (state_q == S_DONE);
    state_dbg = state_q;
  end

  // Field capture: the first word of a message also wipes the previous result.
  always_comb begin
    word0_d       = word0_q;
    rest_hdr_d    = rest_hdr_q;
    payload_d     = payload_q;
    payload_cnt_d = payload_cnt_q;
    truncated_d   = truncated_q;
    len_err_d     = len_err_q;
    if (xfer) begin
      case (state_q)
        S_IDLE: begin
          word0_d       = in_data;
          rest_hdr_d    = '0;
          payload_d     = '0;
          payload_cnt_d = '0;
          truncated_d   = 1'b0;
          len_err_d     = in_last;
        end
        S_HDR: begin
          rest_hdr_d = in_data;
        end
        S_PAY: begin
          // A word landing in the last free slot is kept even if it is the
          // final word; only words beyond the last slot mark truncation.
          if (payload_cnt_q < CNT_W'(PAYLOAD_WORDS)) begin
            for (int k = 0; k < PAYLOAD_WORDS; k++) begin
              if (payload_cnt_q == CNT_W'(k)) begin
                payload_d[k*32 +: 32] = in_data;
              end
            end
            payload_cnt_d = payload_cnt_q + CNT_W'(1);
          end else begin
            truncated_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Field registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word0_q       <= '0;
      rest_hdr_q    <= '0;
      payload_q     <= '0;
      payload_cnt_q <= '0;
      truncated_q   <= 1'b0;
      len_err_q     <= 1'b0;
    end else begin
      word0_q       <= word0_d;
      rest_hdr_q    <= rest_hdr_d;
      payload_q     <= payload_d;
      payload_cnt_q <= payload_cnt_d;
      truncated_q   <= truncated_d;
      len_err_q     <= len_err_d;
    end
  end

`ifdef ICMP_CSUM_CHECK_EN
  logic [15:0] acc_q, acc_d;
  logic [15:0] acc_base;

  // 16-bit one's-complement add with end-around carry.
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'b0, s[16]};
  endfunction

  // Sum both halves of every accepted word, discarded words included;
  // the first word of a message restarts the sum from zero.
  always_comb begin
    acc_base = (state_q == S_IDLE) ? 16'h0000 : acc_q;
    acc_d    = acc_q;
    if (xfer) begin
      acc_d = oc_add(oc_add(acc_base, in_data[31:16]), in_data[15:0]);
    end
  end

  // Accumulator register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= 16'h0000;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign csum_ok = (state_q == S_DONE) && (acc_q == 16'hFFFF);
`else
  assign csum_ok = 1'b1;
`endif

  assign icmp_type   = word0_q[31:24];
  assign icmp_code   = word0_q[23:16];
  assign checksum    = word0_q[15:0];
  assign rest_hdr    = rest_hdr_q;
  assign payload     = payload_q;
  assign payload_cnt = payload_cnt_q;
  assign truncated   = truncated_q;
  assign len_err     = len_err_q;

endmodule

// File: tb/tb_icmp_msg_parser.sv
// Testbench for icmp_msg_parser: directed messages plus random messages,
// checked against a message-level reference model.
module tb_icmp_msg_parser;

  localparam int P     = 3;
  localparam int CNT_W = 5;

  typedef struct packed {
    logic [7:0]      t;
    logic [7:0]      c;
    logic [15:0]     cs;
    logic [31:0]     rh;
    logic [P*32-1:0] pl;
    logic [CNT_W-1:0] cnt;
    logic            tr;
    logic            le;
    logic            ok;
  } res_t;

  localparam int EXP_W = $bits(res_t);

  // ---------------- clock / reset / DUT ----------------
  logic              clock;
  logic              reset;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_last;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        icmp_type;
  logic [7:0]        icmp_code;
  logic [15:0]       checksum;
  logic [31:0]       rest_hdr;
  logic [P*32-1:0]   payload;
  logic [CNT_W-1:0]  payload_cnt;
  logic              truncated;
  logic              len_err;
  logic              csum_ok;
  logic [1:0]        state_dbg;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  icmp_msg_parser #(.PAYLOAD_WORDS(P), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .icmp_type(icmp_type), .icmp_code(icmp_code), .checksum(checksum),
    .rest_hdr(rest_hdr), .payload(payload), .payload_cnt(payload_cnt),
    .truncated(truncated), .len_err(len_err), .csum_ok(csum_ok),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0]      msg_q[$];
  logic [EXP_W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the parse result of the whole message in msg_q.
  function automatic res_t model_msg();
    res_t r;
    longint unsigned s;
    int n;
    n = msg_q.size();
    r = '0;
    r.t  = msg_q[0][31:24];
    r.c  = msg_q[0][23:16];
    r.cs = msg_q[0][15:0];
    r.le = (n == 1);
    if (n >= 2) r.rh = msg_q[1];
    for (int i = 2; i < n; i++) begin
      if (i - 2 < P) begin
        r.pl[(i-2)*32 +: 32] = msg_q[i];
        r.cnt = r.cnt + 1'b1;
      end else begin
        r.tr = 1'b1;
      end
    end
    s = 0;
    foreach (msg_q[i]) s += msg_q[i][31:16] + msg_q[i][15:0];
    while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
`ifdef ICMP_CSUM_CHECK_EN
    r.ok = (s == 64'hFFFF);
`else
    r.ok = 1'b1;
`endif
    return r;
  endfunction

  // Compare every output field with an expected result.
  task automatic check_fields(input string tag, input res_t e);
    check_val({tag, ".type"},   icmp_type,   e.t);
    check_val({tag, ".code"},   icmp_code,   e.c);
    check_val({tag, ".csum"},   checksum,    e.cs);
    check_val({tag, ".rest"},   rest_hdr,    e.rh);
    check_val({tag, ".payload"}, payload,    e.pl);
    check_val({tag, ".cnt"},    payload_cnt, e.cnt);
    check_val({tag, ".trunc"},  truncated,   e.tr);
    check_val({tag, ".len_err"}, len_err,    e.le);
    check_val({tag, ".csum_ok"}, csum_ok,    e.ok);
  endtask

  // ---------------- drivers ----------------
  // Offer one word starting at a negedge; returns at the negedge after it moved.
  task automatic send_word(input logic [31:0] w, input logic last);
    int guard;
    in_valid = 1'b1;
    in_data  = w;
    in_last  = last;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    check_val("in_ready_wait", in_ready, 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Send the first n words of msg_q with random idle gaps between them.
  task automatic send_words(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_word(msg_q[i], (i == msg_q.size() - 1));
      if (gaps && i != msg_q.size() - 1) repeat ($urandom_range(0, 2)) @(negedge clock);
    end
  endtask

  // Full message: drive, check one-cycle latency, fields, hold, release.
  task automatic run_msg(input string tag, input int hold, input bit gaps);
    res_t e;
    exp_q.push_back(model_msg());
    send_words(msg_q.size(), gaps);
    e = res_t'(exp_q.pop_front());
    check_val({tag, ".out_valid"}, out_valid, 1'b1);
    check_val({tag, ".in_ready_done"}, in_ready, 1'b0);
    check_fields(tag, e);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check_val({tag, ".hold_valid"}, out_valid, 1'b1);
      check_val({tag, ".hold_ready"}, in_ready, 1'b0);
      check_val({tag, ".hold_payload"}, payload, e.pl);
      check_val({tag, ".hold_rest"}, rest_hdr, e.rh);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check_val({tag, ".released_valid"}, out_valid, 1'b0);
    check_val({tag, ".released_ready"}, in_ready, 1'b1);
    check_val({tag, ".released_state"}, state_dbg, 2'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".in_ready"}, in_ready, 1'b1);
    check_val({tag, ".out_valid"}, out_valid, 1'b0);
    check_val({tag, ".state"}, state_dbg, 2'd0);
    check_val({tag, ".fields"}, {icmp_type, icmp_code, checksum, rest_hdr, payload,
                                 payload_cnt, truncated, len_err}, '0);
`ifdef ICMP_CSUM_CHECK_EN
    check_val({tag, ".csum_ok"}, csum_ok, 1'b0);
`else
    check_val({tag, ".csum_ok"}, csum_ok, 1'b1);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int len;
    logic [15:0] lo;
    longint unsigned s;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clock);

    msg_q = '{32'h0800F7FF, 32'h12340001};
    run_msg("two_word", 2, 1'b0);

    msg_q = '{32'h00000032, 32'h00000000, 32'h00ABAB32, 32'h00ABAB32, 32'h00CAA200};
    run_msg("full_payload", 0, 1'b0);

    msg_q = '{32'h0B000000, 32'hCAFE0001, 32'h11111111, 32'h22222222,
              32'h33333333, 32'h44444444, 32'h55555555};
    run_msg("truncate", 1, 1'b1);

    msg_q = '{32'h03010000};
    run_msg("short", 0, 1'b0);

    msg_q = '{32'h00000032, 32'h00000000, 32'h00ABAB32, 32'h00ABAB32, 32'h00CAA200};
    run_msg("backpressure", 4, 1'b0);

    // Reset in the middle of a message, then the same message again.
    send_words(3, 1'b0);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_val("mid_reset.no_valid", out_valid, 1'b0);
    run_msg("after_reset", 1, 1'b0);

    // Random messages; about half get a final half-word that makes the sum FFFF.
    for (int m = 0; m < 40; m++) begin
      len = $urandom_range(1, P + 4);
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back($urandom());
      if ($urandom_range(0, 1) == 1) begin
        s = 0;
        foreach (msg_q[i]) s += msg_q[i][31:16] + ((i == len - 1) ? 32'd0 : msg_q[i][15:0]);
        while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
        lo = ~s[15:0];
        msg_q[len-1][15:0] = lo;
      end
      run_msg($sformatf("rand%0d", m), $urandom_range(0, 4), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
